// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the FIFO-fed UART transmitter:
//     - 3-bit state encodings and the FSM state type
//     - counter widths
//     - frame_clks(): clk cycles from start-bit edge to end of stop bit
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_REQ    = 3'd1;
  localparam logic [2:0] ENC_CAP    = 3'd2;
  localparam logic [2:0] ENC_START  = 3'd3;
  localparam logic [2:0] ENC_DATA   = 3'd4;
  localparam logic [2:0] ENC_PARITY = 3'd5;
  localparam logic [2:0] ENC_STOP   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_REQ    = ENC_REQ,
    ST_CAP    = ENC_CAP,
    ST_START  = ENC_START,
    ST_DATA   = ENC_DATA,
    ST_PARITY = ENC_PARITY,
    ST_STOP   = ENC_STOP
  } uart_state_t;

  localparam int unsigned BYTE_CNT_W = 16;

  // Start + data + optional parity + stop, each one bit period long.
  function automatic int unsigned frame_clks(input int unsigned clks_per_bit,
                                             input int unsigned data_w,
                                             input bit          parity_en);
    return (data_w + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high for the
//   single cycle in which the count sits at CLKS_PER_BIT-1, i.e. the last cycle
//   of a bit period. restart holds the count at 0 (and suppresses tick) so the
//   first period after restart is a full CLKS_PER_BIT cycles.
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   clear/hold the counter at 0
//   tick     out  one-cycle pulse on the last cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Pulls bytes one at a time from an upstream synchronous FIFO and shifts each
//   out as an 8N1 UART frame, LSB first. One FIFO read per frame, no read-ahead.
//   Optional build macro: UART_TX_PARITY_EN adds an even-parity bit after the
//   data bits (8E1 frame). Default build (macro undefined) sends 8N1.
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   tx_en       in   permission to start a new frame (looked at in IDLE only)
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  registered one-cycle FIFO read strobe
//   tx          out  registered serial line, idles high
//   busy        out  high whenever the FSM is not in IDLE
//   byte_cnt    out  completed-frame counter, wraps at 16 bits
//
// state  | meaning
// IDLE   | line high; wait for tx_en && !fifo_empty, then strobe fifo_rd
// REQ    | fifo_rd high for this one cycle
// CAP    | fifo_dout valid; load shifter, drive start bit
// START  | start bit (low) for one bit period
// DATA   | shift out DATA_W bits, LSB first
// PARITY | even-parity bit for one bit period (parity builds only)
// STOP   | stop bit (high) for one bit period; count the frame
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_dout,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  uart_state_t           state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  fifo_rd_q, fifo_rd_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
`ifdef UART_TX_PARITY_EN
  // The shifter is consumed as bits go out, so parity is captured with the byte.
  logic                  par_q, par_d;
`endif

  logic baud_restart;
  logic baud_tick;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (baud_tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    tx_d         = tx_q;
    fifo_rd_d    = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    baud_restart = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        baud_restart = 1'b1;
        tx_d         = 1'b1;
        if (tx_en && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        // fifo_empty may rise here as our own read lands; the byte is still ours.
        baud_restart = 1'b1;
        state_d      = ST_CAP;
      end

      ST_CAP: begin
        // Baud counter is held at 0 through this cycle, so START gets a full period.
        baud_restart = 1'b1;
        shift_d      = fifo_dout;
        bit_idx_d    = '0;
        tx_d         = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d        = ^fifo_dout;
`endif
        state_d      = ST_START;
      end

      ST_START: begin
        if (baud_tick) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end

      ST_PARITY: begin
        if (baud_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      fifo_rd_q  <= 1'b0;
      byte_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      fifo_rd_q  <= fifo_rd_d;
      byte_cnt_q <= byte_cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign fifo_rd  = fifo_rd_q;
  assign busy     = (state_q != ST_IDLE);
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed bench for fifo_uart_tx with CLKS_PER_BIT=4. A behavioural FIFO with
//   registered read data feeds the DUT; a receiver task samples tx on every
//   falling edge and rebuilds each frame.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;
  import uart_pkg::*;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_rd;
  logic        tx;
  logic        busy;
  logic [15:0] byte_cnt;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT (N),
    .DATA_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .byte_cnt   (byte_cnt)
  );

  // Behavioural FIFO: writer side owned by the stimulus, reader side by this block.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int rd_while_empty = 0;
  int cyc = 0;
  int rd_cyc = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      rd_cnt <= rd_cnt + 1;
      rd_cyc <= cyc;
      if (fifo_empty) begin
        rd_while_empty <= rd_while_empty + 1;
      end else begin
        fifo_dout <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_start(output int waited);
    waited = -1;
    for (int i = 0; i < 2000 && waited < 0; i++) begin
      @(negedge clk);
      if (tx === 1'b0) waited = i;
    end
    if (waited < 0) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Returns with the last stop-bit cycle just sampled.
  task automatic recv(input bit drop_en, output logic [7:0] d, output logic [9:0] vec,
                      output logic par, output int gap, output int st_cyc);
    logic v, stable, start_ok, stop;
    wait_start(gap);
    st_cyc = cyc;
    if (drop_en) tx_en = 1'b0;
    stable   = 1'b1;
    start_ok = 1'b1;
    d        = '0;
    par      = 1'b0;
    for (int c = 1; c < N; c++) begin
      @(negedge clk);
      if (tx !== 1'b0) start_ok = 1'b0;
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      v = tx;
      for (int c = 1; c < N; c++) begin
        @(negedge clk);
        if (tx !== v) stable = 1'b0;
      end
      d[b] = v;
    end
`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    v = tx;
    for (int c = 1; c < N; c++) begin
      @(negedge clk);
      if (tx !== v) stable = 1'b0;
    end
    par = v;
`endif
    @(negedge clk);
    v = tx;
    for (int c = 1; c < N; c++) begin
      @(negedge clk);
      if (tx !== v) stable = 1'b0;
    end
    stop = v;
    check("start_bit", {31'd0, start_ok}, 32'd1);
    check("bit_stable", {31'd0, stable}, 32'd1);
    check("stop_bit", {31'd0, stop}, 32'd1);
`ifdef UART_TX_PARITY_EN
    check("parity_bit", {31'd0, par}, {31'd0, ^d});
`endif
    vec = {stop, d, ~start_ok};
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [9:0] vec;
    logic       par;
    int         gap, st_cyc, lows, w;

    // 1. Reset
    rst   = 1'b1;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", {31'd0, tx}, 32'd1);

    // 5. Reset during data bit 3 of 0xC3 (bit 3 = 0, so tx is low when reset hits)
    tx_en = 1'b1;
    push(8'hC3);
    wait_start(w);
    repeat (N - 1 + 3 * N + 1) @(negedge clk);
    check("pre_abort_tx", {31'd0, tx}, 32'd0);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    check("abort_byte_cnt", {16'd0, byte_cnt}, 32'd0);
    check("abort_consumed", {31'd0, fifo_empty}, 32'd1);
    count_low(30, lows);
    check("abort_no_resend_tx", lows, 32'd0);
    check("abort_rd_cnt", rd_cnt, 32'd1);

    // 2. Single byte 0xA5: line sequence 0,1,0,1,0,0,1,0,1,1 -> {stop,data,start}=0x34A
    push(8'hA5);
    recv(1'b0, d, vec, par, gap, st_cyc);
    check("a5_frame", {22'd0, vec}, 32'h34A);
    check("a5_rd_to_start", st_cyc - rd_cyc, 32'd2);
    check("a5_rd_cnt", rd_cnt, 32'd2);
    @(negedge clk);
    check("a5_busy_drop", {31'd0, busy}, 32'd0);
    check("a5_frame_len", cyc - st_cyc, frame_clks(N, 8, PAR));
    check("a5_byte_cnt", {16'd0, byte_cnt}, 32'd1);

    // 3. Burst of 16 bytes loaded while gated, then released
    tx_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push(8'(i));
    tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      recv(1'b0, d, vec, par, gap, st_cyc);
      check($sformatf("burst_data_%0d", i), {24'd0, d}, i);
      if (i == 1) check("burst_gap", gap, 32'd3);
    end
    @(negedge clk);
    check("burst_rd_cnt", rd_cnt, 32'd18);
    check("burst_rd_while_empty", rd_while_empty, 32'd0);
    check("burst_byte_cnt", {16'd0, byte_cnt}, 32'd17);
    check("burst_busy", {31'd0, busy}, 32'd0);

    // 4. Gating with tx_en
    tx_en = 1'b0;
    push(8'h5A);
    push(8'h81);
    count_low(40, lows);
    check("gate_tx_idle", lows, 32'd0);
    check("gate_no_rd", rd_cnt, 32'd18);
    tx_en = 1'b1;
    recv(1'b1, d, vec, par, gap, st_cyc);
    check("gate_frame_data", {24'd0, d}, 32'h5A);
    count_low(40, lows);
    check("gate_no_next_tx", lows, 32'd0);
    check("gate_no_next_rd", rd_cnt, 32'd19);
    check("gate_fifo_kept", {31'd0, fifo_empty}, 32'd0);
    check("gate_byte_cnt", {16'd0, byte_cnt}, 32'd18);
    tx_en = 1'b1;
    recv(1'b0, d, vec, par, gap, st_cyc);
    check("gate_second_data", {24'd0, d}, 32'h81);
    @(negedge clk);
    check("gate_final_byte_cnt", {16'd0, byte_cnt}, 32'd19);

`ifdef UART_TX_PARITY_EN
    // 6. Even parity on 0x07 (three ones) -> parity bit 1, 11 bit periods
    push(8'h07);
    recv(1'b0, d, vec, par, gap, st_cyc);
    check("par_data", {24'd0, d}, 32'h07);
    check("par_value", {31'd0, par}, 32'd1);
    @(negedge clk);
    check("par_frame_len", cyc - st_cyc, 32'd44);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
